// File: rtl/fmc_i2c_pkg.sv
// Shared types and constants for the FMC424 I2C init sequencer.
package fmc_i2c_pkg;

   typedef enum logic [1:0] {
      OP_WRITE = 2'b00,
      OP_DELAY = 2'b01,
      OP_END   = 2'b11
   } op_e;

   typedef struct packed {
      op_e        op;
      logic [6:0] dev;
      logic [7:0] rga;
      logic [7:0] data;
   } cmd_entry_t;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      ISSUE,
      WAIT_DONE,
      BACKOFF,
      DELAY,
      FINISH,
      FAIL
   } seq_state_e;

   localparam logic [6:0] CLPD_ADDR     = 7'b0111110;
   localparam logic [7:0] CLPD_CTRL_REG = 8'h02;
   localparam logic [7:0] CLPD_LED4_ON  = 8'h01;

endpackage

// File: rtl/fmc424_init_rom.sv
// Fixed FMC424 init table: LED4 on, settle delay, end.
module fmc424_init_rom
   import fmc_i2c_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic [IW-1:0] idx_i,
   output cmd_entry_t    entry_o
);

   always_comb begin
      entry_o = '{op: OP_END, dev: 7'd0, rga: 8'd0, data: 8'd0};
      case (idx_i)
         IW'(0): entry_o = '{op: OP_WRITE, dev: CLPD_ADDR,
                             rga: CLPD_CTRL_REG, data: CLPD_LED4_ON};
         IW'(1): entry_o = '{op: OP_DELAY, dev: 7'd0,
                             rga: 8'd0, data: 8'd10};
         default: ;
      endcase
   end

endmodule

// File: rtl/fmc_i2c_cmd_sequencer.sv
// Walks the init ROM and issues one I2C register write at a time,
// retrying NACKed or timed-out attempts before reporting an error.
module fmc_i2c_cmd_sequencer
   import fmc_i2c_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int MAX_RETRY  = 3,
   parameter int RETRY_GAP  = 1000,
   parameter int TIMEOUT    = 100000,
   parameter int DELAY_TICK = 100,
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          CLK,
   input  logic          rst,
   input  logic          start,
   output logic          tx_valid,
   input  logic          tx_ready,
   output logic [6:0]    tx_dev_addr,
   output logic [7:0]    tx_reg_addr,
   output logic [7:0]    tx_data,
   input  logic          rx_done,
   input  logic          rx_nack,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [IW-1:0] err_index
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int RW = $clog2(MAX_RETRY + 2);
   localparam int GW = $clog2(RETRY_GAP + 1);
   localparam int PW = $clog2(DELAY_TICK + 1);

   seq_state_e    state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [GW-1:0] gcnt_q, gcnt_d;
   logic [15:0]   dcnt_q, dcnt_d;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic          valid_q, valid_d;
   logic [6:0]    dev_q, dev_d;
   logic [7:0]    rga_q, rga_d;
   logic [7:0]    data_q, data_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic [IW-1:0] erri_q, erri_d;
   logic          adv;
   logic          fail;
   cmd_entry_t    ent;

   fmc424_init_rom #(.DEPTH(DEPTH)) u_rom (
      .idx_i   (idx_q),
      .entry_o (ent)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      retry_d = retry_q;
      tcnt_d  = tcnt_q;
      gcnt_d  = gcnt_q;
      dcnt_d  = dcnt_q;
      pcnt_d  = pcnt_q;
      valid_d = valid_q;
      dev_d   = dev_q;
      rga_d   = rga_q;
      data_d  = data_q;
      busy_d  = busy_q;
      done_d  = done_q;
      error_d = error_q;
      erri_d  = erri_q;
      adv     = 1'b0;
      fail    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               busy_d  = 1'b1;
               done_d  = 1'b0;
               error_d = 1'b0;
               idx_d   = '0;
               retry_d = '0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            case (ent.op)
               OP_WRITE: begin
                  dev_d   = ent.dev;
                  rga_d   = ent.rga;
                  data_d  = ent.data;
                  valid_d = 1'b1;
                  state_d = ISSUE;
               end
               OP_DELAY: begin
                  dcnt_d  = {ent.rga, ent.data};
                  pcnt_d  = '0;
                  state_d = DELAY;
               end
               default: state_d = FINISH;
            endcase
         end
         ISSUE: begin
            if (valid_q && tx_ready) begin
               valid_d = 1'b0;
               tcnt_d  = '0;
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (rx_done && !rx_nack) begin
               retry_d = '0;
               adv     = 1'b1;
            end else if (rx_done || tcnt_q == TW'(TIMEOUT - 1)) begin
               fail = 1'b1;
            end else if (tcnt_q != '1) begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         BACKOFF: begin
            if (gcnt_q == GW'(RETRY_GAP - 1)) begin
               valid_d = 1'b1;
               state_d = ISSUE;
            end else begin
               gcnt_d = gcnt_q + 1'b1;
            end
         end
         DELAY: begin
            // finish on the last prescaler tick so count N takes N*TICK cycles
            if (dcnt_q == 16'd0) begin
               adv = 1'b1;
            end else if (pcnt_q == PW'(DELAY_TICK - 1)) begin
               pcnt_d = '0;
               dcnt_d = dcnt_q - 16'd1;
               if (dcnt_q == 16'd1) adv = 1'b1;
            end else begin
               pcnt_d = pcnt_q + 1'b1;
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         FAIL: begin
            error_d = 1'b1;
            erri_d  = idx_q;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (adv) begin
         if (idx_q == IW'(DEPTH - 1)) begin
            state_d = FINISH;
         end else begin
            idx_d   = idx_q + 1'b1;
            state_d = FETCH;
         end
      end
      if (fail) begin
         if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            gcnt_d  = '0;
            state_d = BACKOFF;
         end else begin
            state_d = FAIL;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         retry_q <= '0;
         tcnt_q  <= '0;
         gcnt_q  <= '0;
         dcnt_q  <= '0;
         pcnt_q  <= '0;
         valid_q <= 1'b0;
         dev_q   <= '0;
         rga_q   <= '0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         erri_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         retry_q <= retry_d;
         tcnt_q  <= tcnt_d;
         gcnt_q  <= gcnt_d;
         dcnt_q  <= dcnt_d;
         pcnt_q  <= pcnt_d;
         valid_q <= valid_d;
         dev_q   <= dev_d;
         rga_q   <= rga_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         error_q <= error_d;
         erri_q  <= erri_d;
      end
   end

   assign tx_valid    = valid_q;
   assign tx_dev_addr = dev_q;
   assign tx_reg_addr = rga_q;
   assign tx_data     = data_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = error_q;
   assign err_index   = erri_q;

endmodule

// File: tb/tb_fmc_i2c_cmd_sequencer.sv
// Directed bench for the FMC424 init sequencer with a simple
// controller model answering each handshake after a fixed delay.
module tb_fmc_i2c_cmd_sequencer;

   localparam int TMO      = 50;
   localparam int GAP      = 1000;
   localparam int RESP_DLY = 20;
   localparam logic [22:0] LED4 = 23'h3E0201;

   logic       CLK = 1'b0;
   logic       rst;
   logic       start;
   logic       tx_valid;
   logic       tx_ready;
   logic [6:0] tx_dev_addr;
   logic [7:0] tx_reg_addr;
   logic [7:0] tx_data;
   logic       rx_done;
   logic       rx_nack;
   logic       busy;
   logic       done;
   logic       error;
   logic [2:0] err_index;

   int errs    = 0;
   int checks  = 0;
   int cyc_now = 0;
   int hs_cnt  = 0;
   int hs_at[8];
   int rxd_at[8];
   int vrise;
   logic [22:0] hs_last;
   logic        resp_on;
   logic [7:0]  nack_mask;
   logic        vprev;

   fmc_i2c_cmd_sequencer #(.TIMEOUT(TMO), .RETRY_GAP(GAP)) dut (
      .CLK         (CLK),
      .rst         (rst),
      .start       (start),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_dev_addr (tx_dev_addr),
      .tx_reg_addr (tx_reg_addr),
      .tx_data     (tx_data),
      .rx_done     (rx_done),
      .rx_nack     (rx_nack),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .err_index   (err_index)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc_now <= cyc_now + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge CLK);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
   endtask

   task automatic wait_end(output int cyc);
      cyc = 0;
      while (!(done || error) && cyc < 20000) begin
         @(negedge CLK);
         cyc++;
      end
      chk("wait_bound", 32'(done || error), 1);
   endtask

   // controller model: logs handshakes, answers RESP_DLY cycles later
   initial begin : responder
      int n;
      rx_done = 1'b0;
      rx_nack = 1'b0;
      vprev   = 1'b0;
      vrise   = 0;
      forever begin
         @(negedge CLK);
         #1;
         if (tx_valid === 1'b1 && !vprev) vrise = cyc_now;
         vprev = (tx_valid === 1'b1);
         if (tx_valid === 1'b1 && tx_ready) begin
            n = hs_cnt;
            if (n < 8) hs_at[n] = vrise;
            hs_last = {tx_dev_addr, tx_reg_addr, tx_data};
            hs_cnt++;
            vprev = 1'b0;
            if (resp_on) begin
               repeat (RESP_DLY) @(negedge CLK);
               rx_done = 1'b1;
               rx_nack = nack_mask[n[2:0]];
               if (n < 8) rxd_at[n] = cyc_now + 1;
               @(negedge CLK);
               rx_done = 1'b0;
               rx_nack = 1'b0;
            end
         end
      end
   end

   initial begin : main
      int   cyc;
      logic stable;
      rst       = 1'b0;
      start     = 1'b0;
      tx_ready  = 1'b1;
      resp_on   = 1'b0;
      nack_mask = 8'h00;
      repeat (3) @(negedge CLK);
      chk("rst_valid", tx_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_erridx", err_index, 0);
      chk("rst_fields", {tx_dev_addr, tx_reg_addr, tx_data}, 0);
      rst = 1'b1;

      hs_cnt  = 0;
      resp_on = 1'b1;
      pulse_start();
      chk("t1_busy", busy, 1);
      chk("t1_valid_early", tx_valid, 0);
      @(negedge CLK);
      chk("t1_valid_rise", tx_valid, 1);
      chk("t1_fields", {tx_dev_addr, tx_reg_addr, tx_data}, LED4);
      cyc = 1;
      while (!done && cyc < 5000) begin
         @(negedge CLK);
         cyc++;
      end
      chk("t1_latency", cyc, 1025);
      chk("t1_hs", hs_cnt, 1);
      chk("t1_hs_fields", hs_last, LED4);
      chk("t1_error", error, 0);
      chk("t1_busy_end", busy, 0);

      tx_ready = 1'b0;
      hs_cnt   = 0;
      pulse_start();
      @(negedge CLK);
      chk("t2_valid_rise", tx_valid, 1);
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (tx_valid !== 1'b1 ||
             {tx_dev_addr, tx_reg_addr, tx_data} !== LED4)
            stable = 1'b0;
         @(negedge CLK);
      end
      chk("t2_hold", stable, 1);
      chk("t2_no_hs", hs_cnt, 0);
      tx_ready = 1'b1;
      wait_end(cyc);
      chk("t2_done", done, 1);
      chk("t2_hs", hs_cnt, 1);

      nack_mask = 8'h01;
      hs_cnt    = 0;
      pulse_start();
      wait_end(cyc);
      chk("t3_done", done, 1);
      chk("t3_error", error, 0);
      chk("t3_hs", hs_cnt, 2);
      chk("t3_gap", hs_at[1] - rxd_at[0], GAP);

      nack_mask = 8'h0F;
      hs_cnt    = 0;
      pulse_start();
      wait_end(cyc);
      chk("t4_error", error, 1);
      chk("t4_erridx", err_index, 0);
      chk("t4_busy", busy, 0);
      chk("t4_done", done, 0);
      chk("t4_hs", hs_cnt, 4);

      resp_on   = 1'b0;
      nack_mask = 8'h00;
      hs_cnt    = 0;
      pulse_start();
      wait_end(cyc);
      chk("t5_error", error, 1);
      chk("t5_done", done, 0);
      chk("t5_hs", hs_cnt, 4);
      chk("t5_tmo_gap", hs_at[1] - hs_at[0], TMO + 1 + GAP);

      hs_cnt = 0;
      pulse_start();
      repeat (10) @(negedge CLK);
      chk("t6_busy", busy, 1);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      repeat (4) @(negedge CLK);
      chk("t6_busy_start_hs", hs_cnt, 1);
      chk("t6_busy_start_valid", tx_valid, 0);
      rst = 1'b0;
      @(negedge CLK);
      chk("t6_rst_valid", tx_valid, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_flags", {done, error}, 0);
      chk("t6_rst_fields", {tx_dev_addr, tx_reg_addr, tx_data}, 0);
      rst     = 1'b1;
      resp_on = 1'b1;
      hs_cnt  = 0;
      pulse_start();
      wait_end(cyc);
      chk("t6_replay_done", done, 1);
      chk("t6_replay_hs", hs_cnt, 1);
      chk("t6_replay_fields", hs_last, LED4);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
